wor_line_arbiter: RTL

- Upstream control stage for the shared wired-OR line built from two strength-qualified buffers, each pull1/weak0.
- Arbitrates two requesters so only one buffer is enabled at a time. Presents the winning requester's data to the buffers and reads the resolved line back.
- Flags collisions when readback disagrees with the driven value. Enforces a bounded grant time and a dead turnaround cycle between owners.

---
 rtl/wor_line_if.sv | 30 +++
 rtl/wor_line_arbiter.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/wor_line_if.sv
// Signal bundle between the two requesters, the shared wired-OR line and its arbiter.
// The master side drives requests and the line readback; the arbiter is the slave.
interface wor_line_if #(
  parameter int WIDTH = 4
) ();
  logic             req0;
  logic             req1;
  logic [WIDTH-1:0] data0;
  logic [WIDTH-1:0] data1;
  logic             last0;
  logic             last1;
  logic [WIDTH-1:0] line_in;
  logic             drv0_en;
  logic             drv1_en;
  logic [WIDTH-1:0] drv_data;
  logic [1:0]       grant;
  logic             busy;
  logic             collision;
  logic             timeout;

  modport master (
    output req0, req1, data0, data1, last0, last1, line_in,
    input  drv0_en, drv1_en, drv_data, grant, busy, collision, timeout
  );

  modport slave (
    input  req0, req1, data0, data1, last0, last1, line_in,
    output drv0_en, drv1_en, drv_data, grant, busy, collision, timeout
  );
endinterface

// File: rtl/wor_line_arbiter.sv
// Two-requester arbiter for a wired-OR line of pull1/weak0 buffers: bounded grant time,
// one dead turnaround cycle between owners, and readback collision detection.
module wor_line_arbiter #(
  parameter int WIDTH    = 4,
  parameter int HOLD_MAX = 15,
  parameter int CMP_DLY  = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  wor_line_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2,
    TURN = 2'd3
  } state_t;

  localparam logic [7:0] HOLD_MAX_C = 8'(HOLD_MAX);
  localparam logic [1:0] CMP_DLY_C  = 2'(CMP_DLY);

  state_t           state_r;
  logic             ptr_r;
  logic [7:0]       hold_r;
  logic [1:0]       settle_r;
  logic             mis_r;
  logic             drv0_en_r;
  logic             drv1_en_r;
  logic [WIDTH-1:0] drv_data_r;
  logic [1:0]       grant_r;
  logic             busy_r;
  logic             collision_r;
  logic             timeout_r;

  logic             own_s;
  logic             sel1_s;
  logic             cur_req_s;
  logic             cur_last_s;
  logic [WIDTH-1:0] cur_data_s;
  logic             cmp_en_s;
  logic             mismatch_s;
  logic             coll_s;
  logic             end_s;
  logic             hold_exp_s;
  logic [7:0]       hold_inc_s;
  logic [1:0]       settle_inc_s;

  // Current-owner view of the request inputs and the release conditions.
  always_comb begin
    own_s        = 1'b0;
    sel1_s       = 1'b0;
    cur_req_s    = 1'b0;
    cur_last_s   = 1'b0;
    cur_data_s   = bus.data0;
    cmp_en_s     = 1'b0;
    mismatch_s   = 1'b0;
    coll_s       = 1'b0;
    end_s        = 1'b0;
    hold_exp_s   = 1'b0;
    hold_inc_s   = hold_r;
    settle_inc_s = settle_r;
    if (state_r == OWN1) begin
      own_s      = 1'b1;
      sel1_s     = 1'b1;
      cur_req_s  = bus.req1;
      cur_last_s = bus.last1;
      cur_data_s = bus.data1;
    end else if (state_r == OWN0) begin
      own_s      = 1'b1;
      sel1_s     = 1'b0;
      cur_req_s  = bus.req0;
      cur_last_s = bus.last0;
      cur_data_s = bus.data0;
    end else begin
      own_s      = 1'b0;
    end
    // Readback is trusted only once the line has had CMP_DLY cycles to settle;
    // case-inequality makes undriven or unknown bits count as a disagreement.
    cmp_en_s   = own_s && (settle_r == CMP_DLY_C);
    mismatch_s = cmp_en_s && (bus.line_in !== drv_data_r);
    coll_s     = mismatch_s && mis_r;
    end_s      = cur_last_s || !cur_req_s;
    hold_exp_s = (hold_r >= HOLD_MAX_C);
    if (hold_r != 8'hFF) begin
      hold_inc_s = hold_r + 8'd1;
    end else begin
      hold_inc_s = hold_r;
    end
    if (settle_r != CMP_DLY_C) begin
      settle_inc_s = settle_r + 2'd1;
    end else begin
      settle_inc_s = settle_r;
    end
  end

  // Arbitration FSM; every output is produced here as a register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      ptr_r       <= 1'b0;
      hold_r      <= 8'd0;
      settle_r    <= 2'd0;
      mis_r       <= 1'b0;
      drv0_en_r   <= 1'b0;
      drv1_en_r   <= 1'b0;
      drv_data_r  <= '0;
      grant_r     <= 2'b00;
      busy_r      <= 1'b0;
      collision_r <= 1'b0;
      timeout_r   <= 1'b0;
    end else begin
      collision_r <= 1'b0;
      timeout_r   <= 1'b0;
      case (state_r)
        IDLE: begin
          hold_r   <= 8'd1;
          settle_r <= 2'd0;
          mis_r    <= 1'b0;
          if (bus.req0 && (!bus.req1 || !ptr_r)) begin
            state_r    <= OWN0;
            drv0_en_r  <= 1'b1;
            drv1_en_r  <= 1'b0;
            grant_r    <= 2'b01;
            busy_r     <= 1'b1;
            drv_data_r <= bus.data0;
            timeout_r  <= (HOLD_MAX_C == 8'd1);
          end else if (bus.req1) begin
            state_r    <= OWN1;
            drv0_en_r  <= 1'b0;
            drv1_en_r  <= 1'b1;
            grant_r    <= 2'b10;
            busy_r     <= 1'b1;
            drv_data_r <= bus.data1;
            timeout_r  <= (HOLD_MAX_C == 8'd1);
          end else begin
            state_r    <= IDLE;
            drv0_en_r  <= 1'b0;
            drv1_en_r  <= 1'b0;
            grant_r    <= 2'b00;
            busy_r     <= 1'b0;
          end
        end
        OWN0, OWN1: begin
          // The timeout pulse is issued as the final allowed cycle begins, so
          // expiry itself only has to release the line without a second pulse.
          if (coll_s || hold_exp_s || end_s) begin
            state_r     <= TURN;
            ptr_r       <= !sel1_s;
            hold_r      <= 8'd0;
            settle_r    <= 2'd0;
            mis_r       <= 1'b0;
            drv0_en_r   <= 1'b0;
            drv1_en_r   <= 1'b0;
            grant_r     <= 2'b00;
            busy_r      <= 1'b1;
            collision_r <= coll_s;
          end else begin
            drv_data_r  <= cur_data_s;
            hold_r      <= hold_inc_s;
            settle_r    <= settle_inc_s;
            mis_r       <= mismatch_s;
            timeout_r   <= (hold_inc_s == HOLD_MAX_C);
          end
        end
        TURN: begin
          state_r   <= IDLE;
          drv0_en_r <= 1'b0;
          drv1_en_r <= 1'b0;
          grant_r   <= 2'b00;
          busy_r    <= 1'b0;
        end
        default: begin
          state_r   <= IDLE;
          drv0_en_r <= 1'b0;
          drv1_en_r <= 1'b0;
          grant_r   <= 2'b00;
          busy_r    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.drv0_en   = drv0_en_r;
  assign bus.drv1_en   = drv1_en_r;
  assign bus.drv_data  = drv_data_r;
  assign bus.grant     = grant_r;
  assign bus.busy      = busy_r;
  assign bus.collision = collision_r;
  assign bus.timeout   = timeout_r;

endmodule
